// File: rtl/lpc_tpm_burst_host_if.sv
// Request/response and LAD pad signals of the LPC TPM burst host.
// master is the host's own view; slave is the sequencer/pad side.
interface lpc_tpm_burst_host_if #(
    parameter int unsigned MAX_BYTES = 4
);
    localparam int unsigned CW = $clog2(MAX_BYTES + 1);

    logic [3:0]             inAd;
    logic [3:0]             outAd;
    logic                   enable;
    logic                   frame;
    logic                   start;
    logic                   isWrite;
    logic [15:0]            addr;
    logic                   incAddr;
    logic [CW-1:0]          byteCount;
    logic [8*MAX_BYTES-1:0] wrData;
    logic [8*MAX_BYTES-1:0] rdData;
    logic                   isReady;
    logic                   done;
    logic [1:0]             status;
    logic [CW-1:0]          bytesDone;

    modport master (
        input  inAd, start, isWrite, addr, incAddr, byteCount, wrData,
        output outAd, enable, frame, rdData, isReady, done, status, bytesDone
    );

    modport slave (
        output inAd, start, isWrite, addr, incAddr, byteCount, wrData,
        input  outAd, enable, frame, rdData, isReady, done, status, bytesDone
    );
endinterface

// File: rtl/lpc_tpm_burst_host.sv
// LPC host running bursts of single-byte TPM I/O cycles with SYNC decode,
// wait-state timeout and LFRAME# abort. All pad and status outputs are registered.
module lpc_tpm_burst_host #(
    parameter int unsigned MAX_BYTES    = 4,
    parameter int unsigned SYNC_TIMEOUT = 32,
    parameter int unsigned ABORT_CYCLES = 4
) (
    input logic                  clk,
    input logic                  reset,
    lpc_tpm_burst_host_if.master bus
);
    localparam int unsigned CW   = $clog2(MAX_BYTES + 1);
    localparam int unsigned IW   = $clog2(8 * MAX_BYTES);
    localparam int unsigned CMAX = (SYNC_TIMEOUT > ABORT_CYCLES) ? SYNC_TIMEOUT : ABORT_CYCLES;
    localparam int unsigned TW   = $clog2(CMAX);
    localparam logic [CW-1:0] MaxB = CW'(MAX_BYTES);

    typedef enum logic [3:0] {
        StIdle, StStart, StCycType, StAddr, StWdata, StTar1,
        StSync, StRdata, StTar2, StGap, StAbort
    } state_e;

    state_e                 state_q, state_d;
    logic [TW-1:0]          cnt_q, cnt_d;
    logic [CW-1:0]          byte_q, byte_d, nbytes_q, nbytes_d, bdone_q, bdone_d;
    logic [15:0]            addr_q, addr_d;
    logic                   wr_q, wr_d, inc_q, inc_d, err_q, err_d;
    logic [8*MAX_BYTES-1:0] wd_q, wd_d, rd_q, rd_d;
    logic [1:0]             status_q, status_d;
    logic [3:0]             ad_q, ad_d;
    logic                   en_q, en_d, frame_q, frame_d, done_q, done_d;
    logic [IW-1:0]          rd_idx, wd_idx;
    logic [7:0]             wr_byte;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        byte_d   = byte_q;
        nbytes_d = nbytes_q;
        bdone_d  = bdone_q;
        addr_d   = addr_q;
        wr_d     = wr_q;
        inc_d    = inc_q;
        err_d    = err_q;
        wd_d     = wd_q;
        rd_d     = rd_q;
        status_d = status_q;
        rd_idx   = IW'({byte_q, 3'b000});
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d  = StStart;
                    cnt_d    = '0;
                    byte_d   = '0;
                    bdone_d  = '0;
                    err_d    = 1'b0;
                    status_d = 2'b00;
                    addr_d   = bus.addr;
                    wr_d     = bus.isWrite;
                    inc_d    = bus.incAddr;
                    wd_d     = bus.wrData;
                    nbytes_d = (bus.byteCount == '0 || bus.byteCount > MaxB) ? MaxB : bus.byteCount;
                end
            end
            StStart:   state_d = StCycType;
            StCycType: begin
                state_d = StAddr;
                cnt_d   = '0;
            end
            StAddr: begin
                if (cnt_q == TW'(3)) begin
                    state_d = wr_q ? StWdata : StTar1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + TW'(1);
                end
            end
            StWdata, StTar1, StRdata: begin
                if (state_q == StRdata) begin
                    if (cnt_q[0]) rd_d[rd_idx + IW'(4) +: 4] = bus.inAd;
                    else          rd_d[rd_idx +: 4]          = bus.inAd;
                end
                if (cnt_q == TW'(1)) begin
                    state_d = (state_q == StTar1) ? StSync : (state_q == StWdata) ? StTar1 : StTar2;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + TW'(1);
                end
            end
            StSync: begin
                // Error completes the byte like ready; the burst ends after TAR2.
                if (bus.inAd == 4'b0000 || bus.inAd == 4'b1010) begin
                    if (bus.inAd == 4'b0000) bdone_d = bdone_q + CW'(1);
                    else                     err_d   = 1'b1;
                    state_d = wr_q ? StTar2 : StRdata;
                    cnt_d   = '0;
                end else if (cnt_q == TW'(SYNC_TIMEOUT - 1)) begin
                    state_d = StAbort;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + TW'(1);
                end
            end
            StTar2: begin
                if (cnt_q == TW'(1)) begin
                    cnt_d = '0;
                    if (err_q) begin
                        state_d  = StIdle;
                        status_d = 2'b01;
                    end else if (byte_q == nbytes_q - CW'(1)) begin
                        state_d  = StIdle;
                        status_d = 2'b00;
                    end else begin
                        state_d = StGap;
                    end
                end else begin
                    cnt_d = cnt_q + TW'(1);
                end
            end
            StGap: begin
                state_d = StStart;
                byte_d  = byte_q + CW'(1);
                if (inc_q) addr_d = addr_q + 16'd1;
            end
            StAbort: begin
                if (cnt_q == TW'(ABORT_CYCLES - 1)) begin
                    state_d  = StIdle;
                    cnt_d    = '0;
                    status_d = 2'b10;
                end else begin
                    cnt_d = cnt_q + TW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Pad outputs are derived from the next state so they register in step with it.
    always_comb begin
        frame_d = 1'b1;
        en_d    = 1'b0;
        ad_d    = 4'h0;
        done_d  = (state_d == StIdle) && (state_q != StIdle);
        wd_idx  = IW'({byte_d, 3'b000});
        wr_byte = wd_d[wd_idx +: 8];
        unique case (state_d)
            StStart: begin
                frame_d = 1'b0;
                en_d    = 1'b1;
                ad_d    = 4'b0101;
            end
            StCycType: begin
                en_d = 1'b1;
                ad_d = wr_d ? 4'b0010 : 4'b0000;
            end
            StAddr: begin
                en_d = 1'b1;
                unique case (cnt_d[1:0])
                    2'd0: ad_d = addr_d[15:12];
                    2'd1: ad_d = addr_d[11:8];
                    2'd2: ad_d = addr_d[7:4];
                    2'd3: ad_d = addr_d[3:0];
                endcase
            end
            StWdata: begin
                en_d = 1'b1;
                ad_d = cnt_d[0] ? wr_byte[7:4] : wr_byte[3:0];
            end
            StTar1: begin
                en_d = (cnt_d == '0);
                ad_d = 4'hF;
            end
            StAbort: begin
                frame_d = 1'b0;
                en_d    = 1'b1;
                ad_d    = 4'hF;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            byte_q   <= '0;
            nbytes_q <= '0;
            bdone_q  <= '0;
            addr_q   <= '0;
            wr_q     <= 1'b0;
            inc_q    <= 1'b0;
            err_q    <= 1'b0;
            wd_q     <= '0;
            rd_q     <= '0;
            status_q <= 2'b00;
            ad_q     <= 4'h0;
            en_q     <= 1'b0;
            frame_q  <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            byte_q   <= byte_d;
            nbytes_q <= nbytes_d;
            bdone_q  <= bdone_d;
            addr_q   <= addr_d;
            wr_q     <= wr_d;
            inc_q    <= inc_d;
            err_q    <= err_d;
            wd_q     <= wd_d;
            rd_q     <= rd_d;
            status_q <= status_d;
            ad_q     <= ad_d;
            en_q     <= en_d;
            frame_q  <= frame_d;
            done_q   <= done_d;
        end
    end

    assign bus.outAd     = ad_q;
    assign bus.enable    = en_q;
    assign bus.frame     = frame_q;
    assign bus.rdData    = rd_q;
    assign bus.done      = done_q;
    assign bus.status    = status_q;
    assign bus.bytesDone = bdone_q;
    assign bus.isReady   = reset & (state_q == StIdle);
endmodule

// File: tb/tb_lpc_tpm_burst_host.sv
// Directed bench for lpc_tpm_burst_host: LAD sequences, SYNC waits/error/timeout,
// address increment, back-to-back accept and mid-burst reset.
module tb_lpc_tpm_burst_host;
    localparam int unsigned MAX_BYTES = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    lpc_tpm_burst_host_if #(.MAX_BYTES(MAX_BYTES)) bus ();

    lpc_tpm_burst_host #(
        .MAX_BYTES   (MAX_BYTES),
        .SYNC_TIMEOUT(32),
        .ABORT_CYCLES(4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // outAd is only meaningful while the host drives LAD.
    task automatic chk_lad(input string tag, input logic f, input logic e, input logic [3:0] ad);
        chk({tag, ".frame_en"}, 32'({bus.frame, bus.enable}), 32'({f, e}));
        if (e) chk({tag, ".lad"}, 32'(bus.outAd), 32'(ad));
    endtask

    task automatic issue(input logic wr, input logic [15:0] a, input logic inc,
                         input logic [2:0] n, input logic [31:0] wd);
        bus.isWrite   = wr;
        bus.addr      = a;
        bus.incAddr   = inc;
        bus.byteCount = n;
        bus.wrData    = wd;
        bus.start     = 1'b1;
        @(posedge clk);
        #1;
        bus.start   = 1'b0;
        bus.isWrite = ~wr;
        bus.addr    = ~a;
        bus.incAddr = ~inc;
        bus.wrData  = ~wd;
    endtask

    task automatic hdr(input string t, input logic wr, input logic [15:0] a, input logic [7:0] wd);
        @(negedge clk);
        chk_lad({t, ".start"}, 1'b0, 1'b1, 4'h5);
        chk({t, ".busy"}, 32'(bus.isReady), 32'd0);
        @(negedge clk);
        chk_lad({t, ".cyctype"}, 1'b1, 1'b1, wr ? 4'h2 : 4'h0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk_lad($sformatf("%s.addr%0d", t, i), 1'b1, 1'b1, a[15-4*i -: 4]);
        end
        if (wr) begin
            @(negedge clk);
            chk_lad({t, ".wd_lo"}, 1'b1, 1'b1, wd[3:0]);
            @(negedge clk);
            chk_lad({t, ".wd_hi"}, 1'b1, 1'b1, wd[7:4]);
        end
        @(negedge clk);
        chk_lad({t, ".tar1a"}, 1'b1, 1'b1, 4'hF);
        @(negedge clk);
        chk_lad({t, ".tar1b"}, 1'b1, 1'b0, 4'h0);
    endtask

    task automatic sync_ph(input string t, input int waits, input logic [3:0] wcode,
                           input logic [3:0] fcode);
        for (int i = 0; i < waits; i++) begin
            @(negedge clk);
            chk_lad($sformatf("%s.syncw%0d", t, i), 1'b1, 1'b0, 4'h0);
            bus.inAd = wcode;
        end
        @(negedge clk);
        chk_lad({t, ".syncf"}, 1'b1, 1'b0, 4'h0);
        bus.inAd = fcode;
    endtask

    task automatic tail(input string t, input logic wr, input logic [7:0] rd);
        if (!wr) begin
            @(negedge clk);
            chk_lad({t, ".rd_lo"}, 1'b1, 1'b0, 4'h0);
            bus.inAd = rd[3:0];
            @(negedge clk);
            chk_lad({t, ".rd_hi"}, 1'b1, 1'b0, 4'h0);
            bus.inAd = rd[7:4];
        end
        @(negedge clk);
        chk_lad({t, ".tar2a"}, 1'b1, 1'b0, 4'h0);
        bus.inAd = 4'hF;
        @(negedge clk);
        chk_lad({t, ".tar2b"}, 1'b1, 1'b0, 4'h0);
    endtask

    task automatic one_byte(input string t, input logic wr, input logic [15:0] a,
                            input logic [7:0] wd, input int waits, input logic [3:0] wcode,
                            input logic [3:0] fcode, input logic [7:0] rd);
        hdr(t, wr, a, wd);
        sync_ph(t, waits, wcode, fcode);
        tail(t, wr, rd);
    endtask

    task automatic gap(input string t);
        @(negedge clk);
        chk_lad({t, ".gap"}, 1'b1, 1'b0, 4'h0);
        chk({t, ".gap_done"}, 32'(bus.done), 32'd0);
    endtask

    task automatic end_chk(input string t, input logic [1:0] st, input logic [2:0] bd);
        @(negedge clk);
        chk({t, ".done"}, 32'(bus.done), 32'd1);
        chk({t, ".status"}, 32'(bus.status), 32'(st));
        chk({t, ".bytesDone"}, 32'(bus.bytesDone), 32'(bd));
        chk({t, ".isReady"}, 32'(bus.isReady), 32'd1);
        chk_lad({t, ".idle"}, 1'b1, 1'b0, 4'h0);
    endtask

    task automatic done_low(input string t);
        @(negedge clk);
        chk({t, ".done_low"}, 32'(bus.done), 32'd0);
    endtask

    initial begin
        bus.inAd      = 4'hF;
        bus.start     = 1'b0;
        bus.isWrite   = 1'b0;
        bus.addr      = 16'h0;
        bus.incAddr   = 1'b0;
        bus.byteCount = 3'd0;
        bus.wrData    = 32'h0;

        repeat (3) @(negedge clk);
        chk("rst.frame", 32'(bus.frame), 32'd1);
        chk("rst.enable", 32'(bus.enable), 32'd0);
        chk("rst.outAd", 32'(bus.outAd), 32'd0);
        chk("rst.done", 32'(bus.done), 32'd0);
        chk("rst.status", 32'(bus.status), 32'd0);
        chk("rst.bytesDone", 32'(bus.bytesDone), 32'd0);
        chk("rst.rdData", bus.rdData, 32'd0);
        chk("rst.isReady", 32'(bus.isReady), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("idle.isReady", 32'(bus.isReady), 32'd1);

        // Single read, ready on first SYNC cycle.
        issue(1'b0, 16'h0F24, 1'b0, 3'd1, 32'h0);
        one_byte("t1", 1'b0, 16'h0F24, 8'h00, 0, 4'h6, 4'h0, 8'hA5);
        end_chk("t1", 2'b00, 3'd1);
        chk("t1.rdData", bus.rdData, 32'h0000_00A5);
        done_low("t1");

        // Write burst with address wrap FFFF -> 0000 -> 0001.
        issue(1'b1, 16'hFFFF, 1'b1, 3'd3, 32'h0033_2211);
        one_byte("t2b0", 1'b1, 16'hFFFF, 8'h11, 0, 4'h6, 4'h0, 8'h00);
        gap("t2b0");
        one_byte("t2b1", 1'b1, 16'h0000, 8'h22, 0, 4'h6, 4'h0, 8'h00);
        gap("t2b1");
        one_byte("t2b2", 1'b1, 16'h0001, 8'h33, 0, 4'h6, 4'h0, 8'h00);
        end_chk("t2", 2'b00, 3'd3);
        chk("t2.rdData_held", bus.rdData, 32'h0000_00A5);
        done_low("t2");

        // Two reads at a fixed address with wait states (0110, then an undefined code).
        issue(1'b0, 16'h0C00, 1'b0, 3'd2, 32'h0);
        one_byte("t3b0", 1'b0, 16'h0C00, 8'h00, 3, 4'h6, 4'h0, 8'h3C);
        gap("t3b0");
        one_byte("t3b1", 1'b0, 16'h0C00, 8'h00, 3, 4'h9, 4'h0, 8'h7E);
        end_chk("t3", 2'b00, 3'd2);
        chk("t3.rdData", bus.rdData, 32'h0000_7E3C);

        // Accepted in the done cycle; long wait forever -> timeout abort.
        issue(1'b0, 16'h1234, 1'b0, 3'd1, 32'h0);
        hdr("t4", 1'b0, 16'h1234, 8'h00);
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            chk_lad($sformatf("t4.sync%0d", i), 1'b1, 1'b0, 4'h0);
            bus.inAd = 4'h5;
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk_lad($sformatf("t4.abort%0d", i), 1'b0, 1'b1, 4'hF);
        end
        bus.inAd = 4'hF;
        end_chk("t4", 2'b10, 3'd0);
        chk("t4.rdData_held", bus.rdData, 32'h0000_7E3C);
        done_low("t4");

        // Write burst (byteCount 0 clamps to 4); SYNC error on byte 1 ends it.
        issue(1'b1, 16'h0040, 1'b1, 3'd0, 32'hDDCC_BBAA);
        one_byte("t5b0", 1'b1, 16'h0040, 8'hAA, 0, 4'h6, 4'h0, 8'h00);
        gap("t5b0");
        one_byte("t5b1", 1'b1, 16'h0041, 8'hBB, 0, 4'h6, 4'hA, 8'h00);
        end_chk("t5", 2'b01, 3'd1);
        @(negedge clk);
        chk_lad("t5.no_start", 1'b1, 1'b0, 4'h0);
        chk("t5.done_low", 32'(bus.done), 32'd0);

        // Reset during ADDR drops the burst without a done pulse.
        issue(1'b0, 16'h5555, 1'b0, 3'd1, 32'h0);
        @(negedge clk);
        chk_lad("t6.start", 1'b0, 1'b1, 4'h5);
        @(negedge clk);
        @(negedge clk);
        chk_lad("t6.addr0", 1'b1, 1'b1, 4'h5);
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        chk_lad("t6.after_rst", 1'b1, 1'b0, 4'h0);
        chk("t6.isReady", 32'(bus.isReady), 32'd1);
        chk("t6.done", 32'(bus.done), 32'd0);
        chk("t6.status", 32'(bus.status), 32'd0);
        chk("t6.rdData", bus.rdData, 32'd0);
        done_low("t6");
        issue(1'b0, 16'h00FF, 1'b0, 3'd1, 32'h0);
        one_byte("t6b", 1'b0, 16'h00FF, 8'h00, 1, 4'h5, 4'h0, 8'h42);
        end_chk("t6b", 2'b00, 3'd1);
        chk("t6b.rdData", bus.rdData, 32'h0000_0042);
        done_low("t6b");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
